// File: rtl/i2c_config_sequencer.sv
// i2c_config_sequencer
// Walks a register table and issues one I2C write per entry through the
// I2C controller. Entries flagged as delays are waited out instead of written.
// A failed write (NACK, or no END handshake within the watchdog window) is
// retried a bounded number of times before the sequence stops with ERROR.
module i2c_config_sequencer #(
  parameter int         LUT_SIZE   = 200,
  parameter int         IDX_W      = 8,
  parameter logic [7:0] SLAVE_ADDR = 8'h60,
  parameter int         MAX_RETRY  = 3,
  parameter int         GAP_CYCLES = 4,
  parameter int         DELAY_UNIT = 1000,
  parameter int         INIT_DELAY = 2000
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic             START,
  output logic [IDX_W-1:0] LUT_INDEX,
  input  logic [16:0]      LUT_DATA,
  output logic [23:0]      I2C_DATA,
  output logic             I2C_GO,
  output logic             I2C_W_R,
  input  logic             I2C_END,
  input  logic             I2C_ACK,
  output logic             BUSY,
  output logic             DONE,
  output logic             ERROR,
  output logic [IDX_W-1:0] ERR_INDEX
);

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(LUT_SIZE - 1);
  localparam logic [31:0]      INIT_LAST = 32'(INIT_DELAY - 1);
  localparam logic [31:0]      GAP_LAST  = 32'(GAP_CYCLES - 1);
  localparam logic [31:0]      WD_LAST   = 32'd63;
  localparam logic [7:0]       RETRY_MAX = 8'(MAX_RETRY);

  typedef enum logic [3:0] {
    S_IDLE, S_INIT, S_LOAD, S_GAP, S_ISSUE,
    S_CHECK, S_DELAY, S_NEXT, S_FINISH, S_FAIL
  } state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic [IDX_W-1:0] eidx, eidx_nxt;
  logic [31:0]      cnt, cnt_nxt;
  logic [23:0]      data, data_nxt;
  logic [7:0]       retry, retry_nxt;
  logic             go, go_nxt;
  logic             busy, busy_nxt;
  logic             done, done_nxt;
  logic             err, err_nxt;
  logic             seen_low, seen_low_nxt;
  logic             wd_nack, wd_nack_nxt;

  assign LUT_INDEX = idx;
  assign I2C_DATA  = data;
  assign I2C_GO    = go;
  assign I2C_W_R   = 1'b0;
  assign BUSY      = busy;
  assign DONE      = done;
  assign ERROR     = err;
  assign ERR_INDEX = eidx;

  // State and datapath registers; reset forces GO low so the controller aborts.
  always_ff @(posedge CLOCK) begin
    if (!RESET) begin
      state    <= S_IDLE;
      idx      <= '0;
      eidx     <= '0;
      cnt      <= '0;
      data     <= '0;
      retry    <= '0;
      go       <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      seen_low <= 1'b0;
      wd_nack  <= 1'b0;
    end else begin
      state    <= state_nxt;
      idx      <= idx_nxt;
      eidx     <= eidx_nxt;
      cnt      <= cnt_nxt;
      data     <= data_nxt;
      retry    <= retry_nxt;
      go       <= go_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
      err      <= err_nxt;
      seen_low <= seen_low_nxt;
      wd_nack  <= wd_nack_nxt;
    end
  end

  // Next-state and next-register logic. GO is high exactly in ISSUE and CHECK.
  always_comb begin
    state_nxt    = state;
    idx_nxt      = idx;
    eidx_nxt     = eidx;
    cnt_nxt      = cnt;
    data_nxt     = data;
    retry_nxt    = retry;
    go_nxt       = 1'b0;
    busy_nxt     = busy;
    done_nxt     = done;
    err_nxt      = err;
    seen_low_nxt = seen_low;
    wd_nack_nxt  = wd_nack;
    case (state)
      S_IDLE: begin
        if (START) begin
          state_nxt = S_INIT;
          done_nxt  = 1'b0;
          err_nxt   = 1'b0;
          busy_nxt  = 1'b1;
          idx_nxt   = '0;
          cnt_nxt   = '0;
          retry_nxt = '0;
        end
      end
      S_INIT: begin
        if (cnt == INIT_LAST) begin
          cnt_nxt   = '0;
          state_nxt = S_LOAD;
        end else begin
          cnt_nxt = cnt + 32'd1;
        end
      end
      S_LOAD: begin
        if (LUT_DATA[16]) begin
          // A zero count still spends one cycle in DELAY.
          cnt_nxt   = 32'(LUT_DATA[15:0]) * 32'(DELAY_UNIT);
          state_nxt = S_DELAY;
        end else begin
          data_nxt  = {SLAVE_ADDR, LUT_DATA[15:0]};
          cnt_nxt   = '0;
          state_nxt = S_GAP;
        end
      end
      S_GAP: begin
        if (cnt == GAP_LAST) begin
          cnt_nxt      = '0;
          seen_low_nxt = 1'b0;
          wd_nack_nxt  = 1'b0;
          go_nxt       = 1'b1;
          state_nxt    = S_ISSUE;
        end else begin
          cnt_nxt = cnt + 32'd1;
        end
      end
      S_ISSUE: begin
        go_nxt = 1'b1;
        if (!I2C_END) seen_low_nxt = 1'b1;
        if (seen_low && I2C_END) begin
          state_nxt = S_CHECK;
        end else if (cnt == WD_LAST) begin
          // Controller never completed its handshake: treat as a NACK.
          wd_nack_nxt = 1'b1;
          state_nxt   = S_CHECK;
        end else begin
          cnt_nxt = cnt + 32'd1;
        end
      end
      S_CHECK: begin
        if (!(I2C_ACK || wd_nack)) begin
          retry_nxt = '0;
          state_nxt = S_NEXT;
        end else if (retry < RETRY_MAX) begin
          retry_nxt = retry + 8'd1;
          cnt_nxt   = '0;
          state_nxt = S_GAP;
        end else begin
          state_nxt = S_FAIL;
        end
      end
      S_DELAY: begin
        if (cnt == 32'd0) state_nxt = S_NEXT;
        else              cnt_nxt   = cnt - 32'd1;
      end
      S_NEXT: begin
        if (idx == LAST_IDX) begin
          state_nxt = S_FINISH;
        end else begin
          idx_nxt   = idx + IDX_W'(1);
          state_nxt = S_LOAD;
        end
      end
      S_FINISH: begin
        done_nxt  = 1'b1;
        busy_nxt  = 1'b0;
        state_nxt = S_IDLE;
      end
      S_FAIL: begin
        err_nxt   = 1'b1;
        eidx_nxt  = idx;
        busy_nxt  = 1'b0;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_i2c_config_sequencer.sv
// Bench for i2c_config_sequencer: a behavioural I2C controller answers each
// GO pulse, a monitor logs every issued write, and a transaction-level model
// predicts the write list and final status from the table and NACK plan.
module tb_i2c_config_sequencer;

  localparam int N   = 8;
  localparam int IW  = 3;
  localparam int MR  = 3;
  localparam int GAP = 4;
  localparam int DU  = 10;
  localparam int ID  = 20;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [IW-1:0] lut_index;
  logic [16:0]   lut_data;
  logic [23:0]   i2c_data;
  logic          go, w_r;
  logic          end_s = 1'b1;
  logic          ack = 1'b0;
  logic          busy, done, error;
  logic [IW-1:0] err_index;

  logic [16:0] tbl [N];
  int          nk  [N];
  int          att [N];
  bit          stuck = 1'b0;

  assign lut_data = tbl[lut_index];

  always #5 clk = ~clk;

  i2c_config_sequencer #(
    .LUT_SIZE(N), .IDX_W(IW), .SLAVE_ADDR(8'h60), .MAX_RETRY(MR),
    .GAP_CYCLES(GAP), .DELAY_UNIT(DU), .INIT_DELAY(ID)
  ) dut (
    .CLOCK(clk), .RESET(rst_n), .START(start), .LUT_INDEX(lut_index),
    .LUT_DATA(lut_data), .I2C_DATA(i2c_data), .I2C_GO(go), .I2C_W_R(w_r),
    .I2C_END(end_s), .I2C_ACK(ack), .BUSY(busy), .DONE(done),
    .ERROR(error), .ERR_INDEX(err_index)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s got %0d want %0d..%0d", nm, act, lo, hi);
    end
  endtask

  // Controller model and write monitor, both away from the active edge.
  logic [23:0] wr_data[$];
  int          wr_idx[$];
  int          wr_low[$];
  int          ccnt = 0;
  int          lowcnt = 0;
  int          unstable_n = 0;
  bit          cur_nack = 1'b0;
  bit          go_prev = 1'b0;
  logic [23:0] rise_data = '0;

  always @(negedge clk) begin
    if (go && !go_prev) begin
      wr_data.push_back(i2c_data);
      wr_idx.push_back(int'(lut_index));
      wr_low.push_back(lowcnt);
      att[lut_index] = att[lut_index] + 1;
      cur_nack  = stuck ? 1'b0 : (att[lut_index] <= nk[lut_index]);
      rise_data = i2c_data;
      ccnt      = 0;
    end
    if (go && i2c_data != rise_data) unstable_n++;
    if (go) begin
      ccnt++;
      end_s  = stuck ? 1'b1 : !(ccnt >= 3 && ccnt < 35);
      ack    = cur_nack;
      lowcnt = 0;
    end else begin
      ccnt   = 0;
      end_s  = 1'b1;
      ack    = 1'b1;
      lowcnt++;
    end
    go_prev = go;
  end

  // Transaction-level reference: which writes happen, and how it ends.
  logic [23:0] m_data[$];
  int          m_idx[$];
  int          m_min[$];
  int          m_max[$];
  bit          m_done, m_err;
  int          m_eidx;

  task automatic model_run();
    int dly;
    int nd;
    bit first;
    dly = 0; nd = 0; first = 1'b1;
    m_data.delete(); m_idx.delete(); m_min.delete(); m_max.delete();
    m_done = 1'b1; m_err = 1'b0; m_eidx = 0;
    for (int i = 0; i < N; i++) begin
      int nfail;
      int natt;
      if (tbl[i][16]) begin
        dly += int'(tbl[i][15:0]) * DU;
        nd++;
        continue;
      end
      nfail = stuck ? MR + 1 : nk[i];
      natt  = (nfail > MR) ? MR + 1 : nfail + 1;
      for (int a = 0; a < natt; a++) begin
        int lo;
        lo = GAP + ((a == 0) ? dly + (first ? ID : 0) : 0);
        m_data.push_back({8'h60, tbl[i][15:0]});
        m_idx.push_back(i);
        m_min.push_back(lo);
        m_max.push_back((first && a == 0) ? 1000000 : lo + 4 + 3 * nd);
        first = 1'b0;
      end
      dly = 0; nd = 0;
      if (nfail > MR) begin
        m_done = 1'b0; m_err = 1'b1; m_eidx = i;
        break;
      end
    end
  endtask

  task automatic launch();
    @(negedge clk);
    wr_data.delete(); wr_idx.delete(); wr_low.delete();
    unstable_n = 0;
    lowcnt = 0;
    for (int i = 0; i < N; i++) att[i] = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_case(input string nm, input bit use_x, input bit x_dn,
                          input bit x_er, input int x_eidx, input int x_nwr);
    int cyc;
    int n;
    model_run();
    launch();
    cyc = 0;
    while (wr_data.size() < 2 && cyc < 3000) begin @(negedge clk); cyc++; end
    chk({nm, "_second_write_seen"}, int'(cyc < 3000), 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({nm, "_busy_mid"}, int'(busy), 1);
    cyc = 0;
    while (!(done || error) && cyc < 8000) begin @(negedge clk); cyc++; end
    chk({nm, "_completes"}, int'(cyc < 8000), 1);
    repeat (2) @(negedge clk);
    chk({nm, "_busy_end"}, int'(busy), 0);
    chk({nm, "_go_end"}, int'(go), 0);
    chk({nm, "_w_r"}, int'(w_r), 0);
    chk({nm, "_done"}, int'(done), int'(m_done));
    chk({nm, "_error"}, int'(error), int'(m_err));
    if (m_err) chk({nm, "_err_index"}, int'(err_index), m_eidx);
    chk({nm, "_data_stable"}, unstable_n, 0);
    chk({nm, "_n_writes"}, wr_data.size(), m_data.size());
    n = (wr_data.size() < m_data.size()) ? wr_data.size() : m_data.size();
    for (int k = 0; k < n; k++) begin
      chk($sformatf("%s_w%0d_data", nm, k), int'(wr_data[k]), int'(m_data[k]));
      chk($sformatf("%s_w%0d_idx", nm, k), wr_idx[k], m_idx[k]);
      chk_rng($sformatf("%s_w%0d_go_low", nm, k), wr_low[k], m_min[k], m_max[k]);
    end
    if (use_x) begin
      chk({nm, "_tbl_done"}, int'(done), int'(x_dn));
      chk({nm, "_tbl_error"}, int'(error), int'(x_er));
      if (x_er) chk({nm, "_tbl_err_index"}, int'(err_index), x_eidx);
      chk({nm, "_tbl_n_writes"}, wr_data.size(), x_nwr);
    end
  endtask

  typedef struct packed {
    logic [N-1:0][16:0] lut;
    logic [N-1:0][2:0]  nack;
    logic               stk;
    logic               dn;
    logic               er;
    logic [IW-1:0]      eidx;
    logic [7:0]         nwr;
  } vec_t;

  vec_t vecs [5];

  task automatic load_vec(input vec_t v);
    for (int i = 0; i < N; i++) begin
      tbl[i] = v.lut[i];
      nk[i]  = int'(v.nack[i]);
    end
    stuck = v.stk;
  endtask

  initial begin
    logic [N-1:0][16:0] base;
    int cyc;
    base[0] = 17'h0FF01; base[1] = 17'h01280; base[2] = 17'h01100; base[3] = 17'h00A05;
    base[4] = 17'h00B06; base[5] = 17'h00C07; base[6] = 17'h00D08; base[7] = 17'h00E09;
    for (int k = 0; k < 5; k++) begin
      vecs[k].lut = base; vecs[k].nack = '0; vecs[k].stk = 1'b0;
      vecs[k].dn = 1'b1; vecs[k].er = 1'b0; vecs[k].eidx = '0; vecs[k].nwr = 8'd8;
    end
    vecs[1].nack[1] = 3'd2; vecs[1].nwr = 8'd10;
    vecs[2].nack[2] = 3'd7; vecs[2].dn = 1'b0; vecs[2].er = 1'b1;
    vecs[2].eidx = 3'd2; vecs[2].nwr = 8'd6;
    vecs[3].lut[3] = {1'b1, 16'd3}; vecs[3].lut[7] = {1'b1, 16'd0}; vecs[3].nwr = 8'd6;
    vecs[4].stk = 1'b1; vecs[4].dn = 1'b0; vecs[4].er = 1'b1; vecs[4].nwr = 8'd4;
    load_vec(vecs[0]);

    repeat (3) @(negedge clk);
    chk("rst_go", int'(go), 0);
    chk("rst_i2c_data", int'(i2c_data), 0);
    chk("rst_lut_index", int'(lut_index), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_error", int'(error), 0);
    chk("rst_err_index", int'(err_index), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int k = 0; k < 5; k++) begin
      load_vec(vecs[k]);
      run_case($sformatf("vec%0d", k), 1'b1, vecs[k].dn, vecs[k].er,
               int'(vecs[k].eidx), int'(vecs[k].nwr));
      if (k == 3) begin
        for (int j = 0; j < wr_idx.size(); j++)
          if (wr_idx[j] == 4) chk_rng("delay_gap_entry4", wr_low[j], 3 * DU, 3 * DU + GAP + 6);
      end
    end

    // Reset in the middle of entry 5's transaction, then restart from index 0.
    load_vec(vecs[0]);
    launch();
    cyc = 0;
    while (!(go && lut_index == 3'd5) && cyc < 3000) begin @(negedge clk); cyc++; end
    chk("reset_reach_entry5", int'(cyc < 3000), 1);
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_go", int'(go), 0);
    chk("midrst_i2c_data", int'(i2c_data), 0);
    chk("midrst_lut_index", int'(lut_index), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_error", int'(error), 0);
    chk("midrst_err_index", int'(err_index), 0);
    run_case("after_reset", 1'b1, 1'b1, 1'b0, 0, 8);

    // Randomized tables and NACK plans against the model.
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < N; i++) begin
        tbl[i] = ($urandom % 5 == 0) ? {1'b1, 16'($urandom_range(0, 3))}
                                     : {1'b0, 16'($urandom)};
        nk[i]  = ($urandom % 3 == 0) ? int'($urandom_range(1, 4)) : 0;
      end
      stuck = 1'b0;
      run_case($sformatf("rand%0d", r), 1'b0, 1'b0, 1'b0, 0, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL global_timeout got running want finished");
    $fatal(1, "time limit");
  end

endmodule
